// File: rtl/vproc_mem_resp.sv
// vproc_mem_resp: word-addressed memory responder for the Vicuna/Ibex
// memory port. It accepts one request per granted cycle and returns every
// response in order after a fixed MEM_LATENCY. An optional periodic stall
// withholds the grant. Addresses beyond MEM_SZ are flagged as errors. It
// also keeps saturating request and error counters.
//
// Handshake: on the request side, mem_req_i is "valid" and mem_gnt_o is
// "ready". A request transfers on a rising edge where both are high. The
// requester holds mem_req_i and all request fields stable until it is
// granted. The grant depends only on mem_req_i and the stall position. It
// never depends on the address or on response state. The response side has
// no ready signal: each cycle with mem_rvalid_o high is exactly one
// response, and responses come back in acceptance order. mem_err_o and
// mem_rdata_o are meaningful only while mem_rvalid_o is high; otherwise they
// keep their last value.
module vproc_mem_resp #(
  parameter int unsigned MEM_W        = 32,
  parameter int unsigned MEM_SZ       = 262144,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STALL_PERIOD = 0,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mem_req_i,
  output logic               mem_gnt_o,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic               mem_err_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  output logic [CNT_W-1:0]   req_cnt_o,
  output logic [CNT_W-1:0]   err_cnt_o
);

  localparam int unsigned BYTES  = MEM_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned ADDR_W = $clog2(MEM_SZ);
  localparam int unsigned DEPTH  = MEM_SZ / BYTES;
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned LAST   = MEM_LATENCY - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             stall;
  logic             accept;
  logic             addr_err;
  logic [IDX_W-1:0] idx;
  logic [MEM_W-1:0] rd_word;
  logic [MEM_W-1:0] resp_data;
  logic             unused_addr_bits;

  // ---------------------------------------------------------------------------
  // Periodic stall: the grant is withheld in the last slot of every period.
  // ---------------------------------------------------------------------------
  if (STALL_PERIOD >= 2) begin : g_stall
    localparam int unsigned     SC_W   = $clog2(STALL_PERIOD);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALL_PERIOD - 1);

    logic [SC_W-1:0] stall_cnt_q;
    logic [SC_W-1:0] stall_cnt_d;

    // Next position in the stall period, wrapping after the last slot.
    always_comb begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
      if (stall_cnt_q == SC_MAX) begin
        stall_cnt_d = '0;
      end
    end

    // Free-running stall position register; it runs whether or not requests arrive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_cnt_q <= '0;
      end else begin
        stall_cnt_q <= stall_cnt_d;
      end
    end

    assign stall = (stall_cnt_q == SC_MAX);
  end else begin : g_no_stall
    assign stall = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign mem_gnt_o = mem_req_i & ~stall;
  assign accept    = mem_req_i & mem_gnt_o;

  // Sub-word address bits select nothing; misaligned addresses simply alias
  // onto their containing word.
  assign unused_addr_bits = ^mem_addr_i[OFF_W-1:0];
  assign idx              = mem_addr_i[ADDR_W-1:OFF_W];
  assign addr_err         = |mem_addr_i[31:ADDR_W];

  // ---------------------------------------------------------------------------
  // Storage array. It has no reset so that contents survive a reset and can
  // be preloaded by hierarchy.
  // ---------------------------------------------------------------------------
  logic [MEM_W-1:0] mem [DEPTH];

  assign rd_word = mem[idx];

  // Write responses and errored reads carry zero data.
  assign resp_data = (mem_we_i || addr_err) ? '0 : rd_word;

  // Byte-masked write; it commits on the accept edge, so any later read sees it.
  always_ff @(posedge clk_i) begin
    if (accept && mem_we_i && !addr_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (mem_be_i[i]) begin
          mem[idx][8*i +: 8] <= mem_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline. Stage 0 is loaded at accept, and the output comes from
  // stage LAST. Payload moves only together with a valid entry, so an empty
  // slot leaves the previous err/rdata in place downstream.
  // ---------------------------------------------------------------------------
  logic [MEM_LATENCY-1:0] vld_q;
  logic [MEM_LATENCY-1:0] vld_d;
  logic [MEM_LATENCY-1:0] perr_q;
  logic [MEM_LATENCY-1:0] perr_d;
  logic [MEM_W-1:0]       pdata_q [MEM_LATENCY];
  logic [MEM_W-1:0]       pdata_d [MEM_LATENCY];

  // Shift the response pipeline by one stage; stage 0 takes the new accept.
  always_comb begin
    vld_d   = '0;
    perr_d  = perr_q;
    pdata_d = pdata_q;

    vld_d[0] = accept;
    if (accept) begin
      perr_d[0]  = addr_err;
      pdata_d[0] = resp_data;
    end

    for (int k = 1; k < MEM_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        perr_d[k]  = perr_q[k-1];
        pdata_d[k] = pdata_q[k-1];
      end
    end
  end

  // Pipeline registers. Reset drops every in-flight response at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      perr_q <= '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        pdata_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      perr_q <= perr_d;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        pdata_q[k] <= pdata_d[k];
      end
    end
  end

  assign mem_rvalid_o = vld_q[LAST];
  assign mem_err_o    = perr_q[LAST];
  assign mem_rdata_o  = pdata_q[LAST];

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] req_cnt_q;
  logic [CNT_W-1:0] req_cnt_d;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  // Saturating increments. The error count is bumped on the same edge that
  // presents the errored response, so it already includes that response
  // while rvalid is high.
  always_comb begin
    req_cnt_d = req_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept && (req_cnt_q != CNT_MAX)) begin
      req_cnt_d = req_cnt_q + CNT_W'(1);
    end
    if (vld_d[LAST] && perr_d[LAST] && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      req_cnt_q <= req_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign req_cnt_o = req_cnt_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_vproc_mem_resp.sv
// tb_vproc_mem_resp: three responder configurations run side by side:
//   cfg0: latency 1, no stall, 256 KiB
//   cfg1: latency 4, no stall, 4 KiB, 4-bit counters
//   cfg2: latency 3, stall 1-in-4, 1 KiB
// Each configuration is checked cycle by cycle against a transaction-level
// model. The model holds a word array, a queue of expected responses tagged
// with their due cycle, and a cycle count since reset that yields the stall
// slots.
module tb_vproc_mem_resp;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One DUT plus driver and scoreboard per configuration
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 4 : 3;
    localparam int unsigned SP  = (g == 2) ? 4 : 0;
    localparam int unsigned SZ  = (g == 0) ? 262144 : (g == 1) ? 4096 : 1024;
    localparam int unsigned CW  = (g == 1) ? 4 : 16;
    localparam int unsigned SPD = (SP >= 2) ? SP : 1;
    localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

    logic          rst_n;
    logic          req;
    logic          we;
    logic          gnt;
    logic          rvalid;
    logic          err;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [3:0]    be;
    logic [CW-1:0] req_cnt;
    logic [CW-1:0] err_cnt;
    logic          done;

    vproc_mem_resp #(
      .MEM_W       (32),
      .MEM_SZ      (SZ),
      .MEM_LATENCY (LAT),
      .STALL_PERIOD(SP),
      .CNT_W       (CW)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mem_req_i   (req),
      .mem_gnt_o   (gnt),
      .mem_addr_i  (addr),
      .mem_we_i    (we),
      .mem_be_i    (be),
      .mem_wdata_i (wdata),
      .mem_rvalid_o(rvalid),
      .mem_err_o   (err),
      .mem_rdata_o (rdata),
      .req_cnt_o   (req_cnt),
      .err_cnt_o   (err_cnt)
    );

    // Reference model state
    logic [31:0]     m_mem [16];
    logic [31:0]     exp_q [$];
    logic            exp_err_q [$];
    int unsigned     exp_due_q [$];
    int unsigned     cyc;
    longint unsigned m_req;
    longint unsigned m_err;
    logic [31:0]     m_rdata;
    logic            m_rerr;
    logic [31:0]     ra;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check($sformatf("cfg%0d %s", g, tag), obs, exp);
    endtask

    task automatic model_reset();
      exp_q.delete();
      exp_err_q.delete();
      exp_due_q.delete();
      cyc     = 0;
      m_req   = 0;
      m_err   = 0;
      m_rdata = '0;
      m_rerr  = 1'b0;
    endtask

    // Apply one accepted request to the model at the current accept cycle.
    task automatic model_accept();
      logic        e;
      int unsigned w;
      logic [31:0] d;
      e = (addr >= SZ);
      w = ((addr % SZ) / 4) % 16;
      d = '0;
      if (m_req != CMAX) m_req++;
      if (we) begin
        if (!e) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) m_mem[w][8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end else if (!e) begin
        d = m_mem[w];
      end
      exp_q.push_back(d);
      exp_err_q.push_back(e);
      exp_due_q.push_back(cyc + LAT - 1);
    endtask

    // Compare the response side and the counters with the model.
    task automatic check_outputs();
      logic exp_v;
      exp_v = 1'b0;
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        exp_v   = 1'b1;
        m_rdata = exp_q.pop_front();
        m_rerr  = exp_err_q.pop_front();
        void'(exp_due_q.pop_front());
        if (m_rerr && m_err != CMAX) m_err++;
      end
      chk("rvalid", rvalid, exp_v);
      chk("err", err, m_rerr);
      chk("rdata", rdata, m_rdata);
      chk("req_cnt", req_cnt, m_req);
      chk("err_cnt", err_cnt, m_err);
    endtask

    // One clock cycle: called just after a negedge, with the inputs driven.
    task automatic step(output logic acc);
      logic exp_gnt;
      #1;
      exp_gnt = req && !((SP >= 2) && ((cyc % SPD) == SPD - 1));
      chk("gnt", gnt, exp_gnt);
      acc = exp_gnt;
      @(posedge clk);
      cyc++;
      if (acc) model_accept();
      @(negedge clk);
      check_outputs();
    endtask

    // Present a request and hold it until it is granted. The request is left
    // asserted so that the next call can follow back to back.
    task automatic do_req(input logic we_i, input logic [31:0] a_i,
                          input logic [3:0] be_i, input logic [31:0] d_i);
      logic acc;
      acc   = 1'b0;
      req   = 1'b1;
      we    = we_i;
      addr  = a_i;
      be    = be_i;
      wdata = d_i;
      for (int k = 0; k < 16 && !acc; k++) step(acc);
    endtask

    task automatic idle(input int n);
      logic acc;
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      be    = '0;
      wdata = '0;
      for (int k = 0; k < n; k++) step(acc);
    endtask

    // Assert reset at a negedge, check the reset values, then release it
    // after n cycles.
    task automatic do_reset(input int n);
      req   = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("gnt_rst", gnt, 1'b0);
      check_outputs();
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
    endtask

    initial begin
      done  = 1'b0;
      rst_n = 1'b0;
      req   = 1'b0;
      we    = 1'b0;
      addr  = '0;
      be    = '0;
      wdata = '0;
      ra    = '0;
      model_reset();
      @(negedge clk);
      do_reset(2);

      // Preload the 16-word window: words 0..7 get 0..7 and word 8 gets
      // AABBCCDD.
      for (int i = 0; i < 16; i++) begin
        do_req(1'b1, 32'(4 * i), 4'hF,
               (i == 8) ? 32'hAABBCCDD : ((i < 8) ? 32'(i) : $urandom));
      end
      idle(LAT + 1);

      // Back-to-back reads of words 0..7.
      for (int i = 0; i < 8; i++) do_req(1'b0, 32'(4 * i), 4'h0, 32'h0);
      idle(LAT + 1);

      // Full write, then read back; partial byte-enable merge; misaligned alias.
      do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      do_req(1'b1, 32'h20, 4'b0101, 32'h11223344);
      do_req(1'b0, 32'h20, 4'h0, 32'h0);
      do_req(1'b0, 32'h23, 4'h0, 32'h0);
      idle(LAT + 1);

      // Out-of-range read and write; the write must leave word 0 untouched.
      do_req(1'b0, SZ, 4'h0, 32'h0);
      do_req(1'b1, SZ, 4'hF, 32'h5A5A5A5A);
      do_req(1'b0, 32'h0, 4'h0, 32'h0);
      do_req(1'b0, 32'h8000_0000, 4'h0, 32'h0);
      // be = 0 writes nothing but still responds.
      do_req(1'b1, 32'h4, 4'h0, 32'hFFFFFFFF);
      do_req(1'b0, 32'h4, 4'h0, 32'h0);
      idle(LAT + 1);

      // Request held high across 12 cycles; stall slots must drop the grant.
      for (int i = 0; i < 12; i++) do_req(1'b0, 32'(4 * (i % 16)), 4'h0, 32'h0);
      idle(LAT + 1);

      // Random traffic: idles, reads, writes, out-of-range and misaligned addresses.
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle(1);
        end else begin
          if ($urandom_range(0, 7) == 0) ra = SZ + 32'(4 * $urandom_range(0, 15));
          else ra = 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
          do_req(1'($urandom_range(0, 1)), ra, 4'($urandom_range(0, 15)), $urandom);
        end
      end
      idle(LAT + 1);

      // Reset mid-flight: two reads are accepted and then dropped. Array
      // contents must survive the reset.
      do_req(1'b1, 32'hC, 4'hF, 32'hCAFEF00D);
      idle(LAT + 1);
      do_req(1'b0, 32'h0, 4'h0, 32'h0);
      do_req(1'b0, 32'h4, 4'h0, 32'h0);
      do_reset(1);
      idle(LAT + 3);
      do_req(1'b0, 32'hC, 4'h0, 32'h0);
      idle(LAT + 1);

      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion and report
  // ---------------------------------------------------------------------------
  initial begin
    logic all_done;
    all_done = 1'b0;
    for (int i = 0; i < 40000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done;
    end
    check("finish_bound", all_done, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
